// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: FSM state encoding, default bus widths and the
// register map of the timer slave this master is typically paired with.
package wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Timer slave register offsets (byte addresses)
  localparam logic [7:0] TMR_TCR0     = 8'h00;
  localparam logic [7:0] TMR_COMPARE0 = 8'h04;
  localparam logic [7:0] TMR_COUNTER0 = 8'h08;
  localparam logic [7:0] TMR_TCR1     = 8'h0C;
  localparam logic [7:0] TMR_COMPARE1 = 8'h10;
  localparam logic [7:0] TMR_COUNTER1 = 8'h14;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator fed by a valid/ready command port.
// One transfer outstanding at a time; the result (read data or timeout error)
// is returned on a valid/ready response port.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_we/adr/sel/dat         command payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_dat, rsp_err           read data (0 for writes/timeouts), timeout flag
//   busy                       a transfer or response is in flight
//   wb_cyc_o .. wb_dat_o       Wishbone initiator outputs (stb mirrors cyc)
//   wb_ack_i, wb_dat_i         Wishbone slave responses
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned AW      = WB_AW,
  parameter int unsigned DW      = WB_DW,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [DW-1:0]   cmd_dat,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            busy,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int unsigned SW    = DW / 8;
  // TIMEOUT=0 still needs a legal one-bit counter
  localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          sel_d   = cmd_sel;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack has priority over a timeout on the same edge
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = busy_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master driving a small timer-like register slave
// that acks one cycle after stb.
module tb_wb_cmd_master;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  logic        s_ack, tb_ack, slave_mute;
  logic [31:0] s_rdat;
  logic [31:0] regs [0:5];
  logic [31:0] wlog_adr [$];
  logic [31:0] wlog_dat [$];

  int n_pass = 0, n_checks = 0;
  int ack_cnt = 0, stb_rise = 0, stb_viol = 0;
  bit ack_prev = 0, stb_prev = 0;

  assign wb_ack_i = s_ack | tb_ack;
  assign wb_dat_i = s_rdat;

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  // Registered-ack slave; register contents survive reset
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ack  <= 1'b0;
      s_rdat <= '0;
    end else begin
      s_ack <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !s_ack && !slave_mute) begin
        s_ack <= 1'b1;
        if (wb_we_o) begin
          if (wb_adr_o < 32'h18) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) regs[wb_adr_o[4:2]][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
          end
          wlog_adr.push_back(wb_adr_o);
          wlog_dat.push_back(wb_dat_o);
        end else begin
          s_rdat <= (wb_adr_o < 32'h18) ? regs[wb_adr_o[4:2]] : 32'h0;
        end
      end
    end
  end

  // Bus monitor: acks taken, stb pulses, stb still high after an ack edge
  always @(negedge clk) begin
    if (ack_prev && wb_stb_o) stb_viol++;
    ack_prev = wb_ack_i && wb_stb_o;
    if (wb_ack_i && wb_stb_o) ack_cnt++;
    if (wb_stb_o && !stb_prev) stb_rise++;
    stb_prev = wb_stb_o;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present a command while idle; returns one edge after the handshake
  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts edges after the handshake until rsp_valid, and cycles with cyc high
  task automatic wait_rsp(output int lat, output int cc);
    bit ok;
    lat = 0; cc = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      if (wb_cyc_o) cc++;
      tick();
      lat++;
    end
    check("rsp_wait_bound", 64'(ok), 64'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("consume_rsp_valid", 64'(rsp_valid), 64'd0);
    check("consume_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  int lat, cc, a0, s0, k;
  bit rdy_seen;
  logic [31:0] bb_adr [4];
  logic [31:0] bb_dat [4];

  initial begin
    reset = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0; cmd_dat = 0;
    rsp_ready = 0; tb_ack = 0; slave_mute = 0;
    for (int i = 0; i < 6; i++) regs[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write COMPARE0
    a0 = ack_cnt; s0 = stb_rise;
    issue(1'b1, 32'(TMR_COMPARE0), 4'hF, 32'h0000_0010);
    check("wr_cyc", 64'(wb_cyc_o), 64'd1);
    check("wr_stb", 64'(wb_stb_o), 64'd1);
    check("wr_we", 64'(wb_we_o), 64'd1);
    check("wr_adr", 64'(wb_adr_o), 64'h04);
    check("wr_sel", 64'(wb_sel_o), 64'hF);
    check("wr_dat", 64'(wb_dat_o), 64'h10);
    check("wr_cmd_ready", 64'(cmd_ready), 64'd0);
    check("wr_busy", 64'(busy), 64'd1);
    wait_rsp(lat, cc);
    check("wr_latency", 64'(lat), 64'd2);
    check("wr_rsp_err", 64'(rsp_err), 64'd0);
    check("wr_rsp_dat", 64'(rsp_dat), 64'd0);
    check("wr_cyc_after", 64'(wb_cyc_o), 64'd0);
    consume();
    check("wr_compare0", 64'(regs[1]), 64'h10);
    check("wr_stb_pulses", 64'(stb_rise - s0), 64'd1);
    check("wr_acks", 64'(ack_cnt - a0), 64'd1);

    // Reads: mapped and unmapped
    issue(1'b0, 32'(TMR_COMPARE0), 4'hF, 32'hDEAD_BEEF);
    check("rd_we", 64'(wb_we_o), 64'd0);
    wait_rsp(lat, cc);
    check("rd_latency", 64'(lat), 64'd2);
    check("rd_rsp_dat", 64'(rsp_dat), 64'h10);
    check("rd_rsp_err", 64'(rsp_err), 64'd0);
    consume();
    issue(1'b0, 32'h18, 4'hF, 32'h0);
    wait_rsp(lat, cc);
    check("rd18_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rd18_rsp_err", 64'(rsp_err), 64'd0);
    consume();

    // Timeout with a silent slave, then late acks
    slave_mute = 1'b1;
    issue(1'b0, 32'(TMR_COUNTER0), 4'hF, 32'h0);
    wait_rsp(lat, cc);
    check("to_latency", 64'(lat), 64'd8);
    check("to_cyc_cycles", 64'(cc), 64'd8);
    check("to_rsp_err", 64'(rsp_err), 64'd1);
    check("to_rsp_dat", 64'(rsp_dat), 64'd0);
    check("to_cyc_low", 64'(wb_cyc_o), 64'd0);
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    check("late_ack_resp_valid", 64'(rsp_valid), 64'd1);
    check("late_ack_resp_err", 64'(rsp_err), 64'd1);
    check("late_ack_resp_cyc", 64'(wb_cyc_o), 64'd0);
    consume();
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    check("late_ack_idle_busy", 64'(busy), 64'd0);
    check("late_ack_idle_valid", 64'(rsp_valid), 64'd0);
    check("late_ack_idle_ready", 64'(cmd_ready), 64'd1);
    slave_mute = 1'b0;

    // Response backpressure with the next command already waiting
    issue(1'b0, 32'(TMR_COMPARE0), 4'hF, 32'h0);
    wait_rsp(lat, cc);
    cmd_we = 1'b1; cmd_adr = 32'(TMR_COMPARE1); cmd_sel = 4'hF; cmd_dat = 32'h0000_00A5;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_dat", 64'(rsp_dat), 64'h10);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_cyc", 64'(wb_cyc_o), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release_ready", 64'(cmd_ready), 64'd1);
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_cyc", 64'(wb_cyc_o), 64'd1);
    check("bp_next_adr", 64'(wb_adr_o), 64'h10);
    wait_rsp(lat, cc);
    check("bp_next_latency", 64'(lat), 64'd2);
    consume();
    check("bp_compare1", 64'(regs[4]), 64'hA5);

    // Back-to-back writes with cmd_valid and rsp_ready held high
    bb_adr[0] = 32'(TMR_TCR0);     bb_dat[0] = 32'h1111_0001;
    bb_adr[1] = 32'(TMR_COMPARE1); bb_dat[1] = 32'h2222_0002;
    bb_adr[2] = 32'(TMR_TCR1);     bb_dat[2] = 32'h3333_0003;
    bb_adr[3] = 32'(TMR_COUNTER1); bb_dat[3] = 32'h4444_0004;
    wlog_adr.delete(); wlog_dat.delete();
    a0 = ack_cnt; s0 = stb_rise; stb_viol = 0;
    k = 0;
    cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = bb_adr[0]; cmd_dat = bb_dat[0];
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 100 && k < 4; c++) begin
      rdy_seen = cmd_ready;
      tick();
      if (rdy_seen) begin
        k++;
        if (k < 4) begin cmd_adr = bb_adr[k]; cmd_dat = bb_dat[k]; end
        else cmd_valid = 1'b0;
      end
    end
    for (int c = 0; c < 40 && busy; c++) tick();
    rsp_ready = 1'b0;
    tick();
    check("b2b_accepted", 64'(k), 64'd4);
    check("b2b_idle", 64'(busy), 64'd0);
    check("b2b_writes", 64'(wlog_adr.size()), 64'd4);
    check("b2b_acks", 64'(ack_cnt - a0), 64'd4);
    check("b2b_stb_pulses", 64'(stb_rise - s0), 64'd4);
    check("b2b_stb_after_ack", 64'(stb_viol), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog_adr.size()) begin
        check("b2b_order_adr", 64'(wlog_adr[i]), 64'(bb_adr[i]));
        check("b2b_order_dat", 64'(wlog_dat[i]), 64'(bb_dat[i]));
      end
    end
    check("b2b_reg_counter1", 64'(regs[5]), 64'h4444_0004);

    // Async reset in the middle of a bus cycle
    slave_mute = 1'b1;
    issue(1'b0, 32'(TMR_COMPARE0), 4'hF, 32'h0);
    tick();
    check("mid_cyc_before", 64'(wb_cyc_o), 64'd1);
    reset = 1'b0;
    #1;
    check("arst_cyc", 64'(wb_cyc_o), 64'd0);
    check("arst_stb", 64'(wb_stb_o), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b1;
    slave_mute = 1'b0;
    tick();
    check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    issue(1'b0, 32'(TMR_COMPARE0), 4'hF, 32'h0);
    wait_rsp(lat, cc);
    check("arst_rd_latency", 64'(lat), 64'd2);
    check("arst_rd_dat", 64'(rsp_dat), 64'h10);
    check("arst_rd_err", 64'(rsp_err), 64'd0);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
